// File: rtl/periph_bus_master.sv
// CPU load/store to select/enable peripheral bus bridge; 3-cycle zero-wait latency, +1 per wait cycle.
// One transfer in flight: req_ready only in IDLE, slave stalls bounded by TIMEOUT, misses answered in 1 cycle.
module periph_bus_master #(
  parameter int          NUM_SLV   = 4,
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int          TIMEOUT   = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  input  logic                   req_we,
  input  logic [31:0]            req_addr,
  input  logic [31:0]            req_wdata,
  output logic                   req_ready,
  output logic                   rsp_valid,
  output logic [31:0]            rsp_rdata,
  output logic                   rsp_err,
  output logic [NUM_SLV-1:0]     psel,
  output logic                   penable,
  output logic                   pwrite,
  output logic [31:0]            paddr,
  output logic [31:0]            pwdata,
  input  logic [NUM_SLV*32-1:0]  prdata,
  input  logic [NUM_SLV-1:0]     pready
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam logic [NUM_SLV-1:0] SEL_ONE = 1;
  localparam logic [4:0]         NSLV    = 5'(NUM_SLV);
  localparam logic [7:0]         TO_CNT  = 8'(TIMEOUT);

  state_t               state_q, state_d;
  logic [NUM_SLV-1:0]   psel_q, psel_d;
  logic                 penable_q, penable_d;
  logic                 pwrite_q, pwrite_d;
  logic [31:0]          paddr_q, paddr_d;
  logic [31:0]          pwdata_q, pwdata_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [31:0]          rsp_rdata_q, rsp_rdata_d;
  logic [7:0]           wait_q, wait_d;

  logic                 hit;
  logic                 ready_sel;
  logic [31:0]          rdata_sel;

  assign hit = (req_addr[31:16] == BASE_ADDR[31:16]) && ({1'b0, req_addr[15:12]} < NSLV);

  // psel_q is one-hot during ACCESS, so masking picks exactly the addressed slave
  always_comb begin
    ready_sel = |(pready & psel_q);
    rdata_sel = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (psel_q[i]) rdata_sel |= prdata[32*i +: 32];
    end
  end

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    wait_d      = wait_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (hit) begin
            state_d  = SETUP;
            psel_d   = SEL_ONE << req_addr[15:12];
            pwrite_d = req_we;
            paddr_d  = {20'b0, req_addr[11:0]};
            pwdata_d = req_wdata;
            wait_d   = '0;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (ready_sel || (wait_q + 8'd1 == TO_CNT)) begin
          state_d     = IDLE;
          psel_d      = '0;
          penable_d   = 1'b0;
          pwrite_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = !ready_sel;
          rsp_rdata_d = (ready_sel && !pwrite_q) ? rdata_sel : 32'h0;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      default: begin
        state_d   = IDLE;
        psel_d    = '0;
        penable_d = 1'b0;
        pwrite_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      wait_q      <= wait_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;

endmodule
